// File: rtl/exec_pkg.sv
// Shared types, width helpers and default sizes for the Banff execute-stage sequencer.
package exec_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2
    } seq_state_t;

    localparam int unsigned DEF_NUM_UNITS  = 4;
    localparam int unsigned DEF_MAX_CYCLES = 32;
    localparam int unsigned DEF_TAG_W      = 5;

    // A unit index is at least one bit wide even for a single-unit build.
    function automatic int unsigned unit_w_f(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w_f(input int unsigned max_cycles);
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/exec_step_counter.sv
// Loadable step counter: holds the clamped op latency and flags the final step.
module exec_step_counter
    import exec_pkg::*;
#(
    parameter int unsigned CNT_W   = cnt_w_f(DEF_MAX_CYCLES),
    parameter int unsigned MAX_VAL = DEF_MAX_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TOP = CNT_W'(MAX_VAL);

    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] load_clamped;

    // Zero latency runs for one step; anything above MAX_VAL is capped.
    always_comb begin
        load_clamped = load_val;
        if (load_val == '0) begin
            load_clamped = ONE;
        end else if (load_val > TOP) begin
            load_clamped = TOP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
            limit <= ONE;
        end else if (load) begin
            count <= '0;
            limit <= load_clamped;
        end else if (enable && (count != TOP - ONE)) begin
            count <= count + ONE;
        end
    end

    assign at_term = (count == limit - ONE);

endmodule

// File: rtl/exec_op_sequencer.sv
// Banff execute-stage sequencer: dispatches one op at a time to one of NUM_UNITS
// functional units, steps its latency and holds the result until writeback takes it.
module exec_op_sequencer
    import exec_pkg::*;
#(
    parameter  int unsigned NUM_UNITS  = DEF_NUM_UNITS,
    parameter  int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
    parameter  int unsigned TAG_W      = DEF_TAG_W,
    localparam int unsigned UNIT_W     = unit_w_f(NUM_UNITS),
    localparam int unsigned CNT_W      = cnt_w_f(MAX_CYCLES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [UNIT_W-1:0]    in_unit,
    input  logic [CNT_W-1:0]     in_cycles,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 in_early_ok,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [CNT_W-1:0]     unit_step,
    output logic [NUM_UNITS-1:0] unit_abort,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAG_W-1:0]     out_tag,
    output logic [UNIT_W-1:0]    out_unit,
    output logic                 out_err,
    output logic                 stall,
    output logic                 busy
);

    seq_state_t state, state_next;

    logic                 accept;
    logic [UNIT_W-1:0]    op_unit;
    logic [TAG_W-1:0]     op_tag;
    logic                 op_early;
    logic                 op_err;
    logic [NUM_UNITS-1:0] op_sel;
    logic [CNT_W-1:0]     step;
    logic                 at_term;
    logic                 early_hit;
    logic                 run_done;

    // DRAIN with out_ready set hands the slot straight to the next op.
    assign in_ready = !flush && ((state == SEQ_IDLE) || ((state == SEQ_DRAIN) && out_ready));
    assign accept   = in_valid && in_ready;
    assign stall    = in_valid && !in_ready;
    assign busy     = (state != SEQ_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            op_unit  <= '0;
            op_tag   <= '0;
            op_early <= 1'b0;
            op_err   <= 1'b0;
        end else if (accept) begin
            op_unit  <= in_unit;
            op_tag   <= in_tag;
            op_early <= in_early_ok;
            op_err   <= (32'(in_unit) >= NUM_UNITS);
        end
    end

    // Out-of-range units decode to all-zero, so an errored op never touches a unit.
    always_comb begin
        op_sel = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (32'(op_unit) == i) begin
                op_sel[i] = 1'b1;
            end
        end
    end

    exec_step_counter #(
        .CNT_W   (CNT_W),
        .MAX_VAL (MAX_CYCLES)
    ) u_step_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .load     (accept),
        .load_val (in_cycles),
        .enable   (state == SEQ_RUN),
        .count    (step),
        .at_term  (at_term)
    );

    assign early_hit = op_early && !op_err && ((unit_done & op_sel) != '0);
    assign run_done  = at_term || early_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unit_start = '0;
        unit_step  = '0;
        unit_abort = '0;
        out_valid  = 1'b0;
        out_tag    = '0;
        out_unit   = '0;
        out_err    = 1'b0;
        unique case (state)
            SEQ_IDLE: begin
                if (accept) begin
                    state_next = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                unit_step = step;
                if ((step == '0) && !op_err) begin
                    unit_start = op_sel;
                end
                if (run_done) begin
                    state_next = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                out_valid = 1'b1;
                out_tag   = op_tag;
                out_unit  = op_unit;
                out_err   = op_err;
                if (out_ready) begin
                    state_next = accept ? SEQ_RUN : SEQ_IDLE;
                end
            end
            default: state_next = SEQ_IDLE;
        endcase
        if (flush) begin
            state_next = SEQ_IDLE;
            if ((state == SEQ_RUN) && !reset) begin
                unit_abort = op_sel;
            end
        end
    end

endmodule

// File: doc/exec_op_sequencer.md
# exec_op_sequencer

Parametrised multi-cycle execute sequencer for the Banff Execute stage. It accepts one decoded operation at a time from the issue side, dispatches it to one of `NUM_UNITS` functional units, and steps a per-operation cycle count. It supports early completion and pipeline flush, then holds the result tag until the writeback side accepts it. It generalises the single-unit execute sequencer to N units with variable latency and a valid/ready handshake on both sides.

## Interface
- `NUM_UNITS`, 4: number of functional units; `UNIT_W = max(1, clog2(NUM_UNITS))`
- `MAX_CYCLES`, 32: largest supported op latency; `CNT_W = clog2(MAX_CYCLES+1)`
- `TAG_W`, 5: width of the destination/ROB tag carried through
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- `clock` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `flush` in 1: kill the in-flight op; synchronous
- `in_valid` in 1: issue side offers an op
- `in_ready` out 1: sequencer can accept
- `in_unit` in UNIT_W: target functional unit
- `in_cycles` in CNT_W: op latency in cycles; 0 is treated as 1
- `in_tag` in TAG_W: tag carried to the output
- `in_early_ok` in 1: op may finish on `unit_done` before the count expires
- `unit_start` out NUM_UNITS: one-hot start pulse
- `unit_step` out CNT_W: current step index, 0-based
- `unit_abort` out NUM_UNITS: one-hot abort pulse on flush
- `unit_done` in NUM_UNITS: unit reports early finish
- `out_valid` out 1: completed op presented
- `out_ready` in 1: writeback accepts
- `out_tag` out TAG_W: tag of the completed op
- `out_unit` out UNIT_W: unit of the completed op
- `out_err` out 1: `in_unit >= NUM_UNITS` was issued
- `stall` out 1: `in_valid && !in_ready`
- `busy` out 1: state is not IDLE

## Operation
- **States.** IDLE, RUN, DRAIN.
- **Ready condition.** `in_ready = !flush && (IDLE || (DRAIN && out_ready))`. This allows a back-to-back handoff in the DRAIN cycle.
- **Accept.** On `in_valid && in_ready`, register unit, cycles (0→1), tag, early_ok and err. Next state is RUN with step = 0.
- **RUN.**
  - `unit_start[unit]` is high only in the first RUN cycle, and never when err is set.
  - `unit_step` = step, incrementing by one each RUN cycle.
  - Completion occurs when step == cycles−1, or when `early_ok && unit_done[unit]`. `unit_done` is ignored when early_ok is 0 or err is set.
  - On completion, go to DRAIN.
- **DRAIN.**
  - `out_valid` = 1; `out_tag`, `out_unit` and `out_err` are held stable until `out_ready`.
  - On `out_ready`: go to RUN if a new op is accepted in the same cycle, otherwise go to IDLE.
- **Flush.** Flush has the highest priority below reset. From any state the next state is IDLE.
  - `unit_abort[unit]` pulses in the flush cycle, but only if the state is RUN.
  - No op is accepted in a flush cycle.
  - An op in DRAIN is dropped and `out_valid` falls on the next cycle.
- **Reset.** State IDLE. All outputs are 0 except `in_ready`, which is 1 once reset deasserts. Reset applied mid-operation is equivalent to flush, but without an abort pulse.
- **Counter width.** Step never exceeds MAX_CYCLES−1. An `in_cycles` value above MAX_CYCLES is clamped to MAX_CYCLES.

## Timing
- Accept in cycle 0 with N cycles gives RUN in cycles 1..N, and `out_valid` first high in cycle N+1.
- Early done sampled at step k gives `out_valid` in cycle k+2.
- `unit_start` appears 1 cycle after accept.
- Back-to-back throughput is one op per N+1 cycles when `out_ready` is held high.
- `unit_done` and `out_ready` are sampled at the rising edge; there are no combinational paths from them to `unit_start`.
- `in_ready` depends combinationally on `out_ready` and `flush` only.

## Structure
- Shared package `exec_pkg` holds:
  - state encoding localparams (`SEQ_IDLE`, `SEQ_RUN`, `SEQ_DRAIN`)
  - `UNIT_W` and `CNT_W` derivation functions
  - default widths for `TAG_W` and `MAX_CYCLES`
- Sub-module `exec_step_counter` is a loadable up-counter with terminal-compare, clear and clamp, parametrised by `CNT_W`.
- The top level holds the FSM, the op register, the one-hot decode and the handshake logic.

## Test plan
- **Reset and single op.** Reset for 2 cycles, then issue unit 2, cycles = 3, tag = 0x11, `out_ready` = 1. Expect `unit_start` = 4'b0100 in cycle 1, `unit_step` = 0,1,2, and `out_valid` with tag 0x11 in cycle 4.
- **Early done.** Issue cycles = 10, early_ok = 1, and assert `unit_done[1]` at step 2. Expect `out_valid` in cycle 4. Repeat with early_ok = 0 and expect `out_valid` in cycle 11.
- **Backpressure and handoff.** Hold `out_ready` low for 5 cycles in DRAIN. Expect outputs stable and `stall` = 1 while `in_valid` is high. Raise `out_ready` with a new op valid: the handoff completes in that cycle and the next `unit_start` follows 1 cycle later.
- **Flush mid-RUN.** Flush at step 1 on unit 0. Expect `unit_abort` = 4'b0001, state IDLE next cycle, no `out_valid`, and `in_ready` low in the flush cycle.
- **Edge encodings.** Issue cycles = 0, then cycles = MAX_CYCLES+5, then `in_unit` = 3 with `NUM_UNITS` = 3. Expect latencies of 1 and MAX_CYCLES respectively. The third op produces no `unit_start` and completes with `out_err` = 1.
